// File: rtl/quadrature_decoder.sv
//==============================================================================
// Module   : quadrature_decoder
// Brief    : 4x A/B quadrature decoder with wrapping position, windowed speed
//            and direction. Optional glitch filter enabled by QDEC_FILTER_EN.
// Revision : 1.0
//==============================================================================
`default_nettype none

module quadrature_decoder #(
   parameter int POS_W    = 16,
   parameter int VEL_W    = 8,
   parameter int WINDOW   = 50000,
   parameter int FILT_LEN = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             enc_a,
   input  logic             enc_b,
   output logic [POS_W-1:0] position,
   output logic [VEL_W-1:0] velocity,
   output logic             direction,
   output logic             vel_valid,
   output logic             err
);

   localparam int ACC_W = VEL_W + 2;
   localparam int WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic [1:0]              a_sync;
   logic [1:0]              b_sync;
   logic [1:0]              synced;
   logic [1:0]              ab;
   logic [1:0]              prev_ab;
   logic [1:0]              idx_cur;
   logic [1:0]              idx_prev;
   logic [1:0]              idx_diff;
   logic                    fwd;
   logic                    rev;
   logic                    illegal;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W:0]   delta;
   logic signed [ACC_W:0]   acc_sum;
   logic signed [ACC_W-1:0] acc_next;
   logic [ACC_W-1:0]        acc_u;
   logic [ACC_W-1:0]        mag;
   logic [VEL_W-1:0]        vel_sat;
   logic [WIN_W-1:0]        win_cnt;
   logic                    win_end;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sync <= 2'b00;
         b_sync <= 2'b00;
      end else begin
         a_sync <= {a_sync[0], enc_a};
         b_sync <= {b_sync[0], enc_b};
      end
   end

   assign synced = {a_sync[1], b_sync[1]};

`ifdef QDEC_FILTER_EN
   localparam int FC_W = $clog2(FILT_LEN);

   // A channel flips only after FILT_LEN consecutive samples disagree with it
   for (genvar ch = 0; ch < 2; ch++) begin : g_filt
      logic [FC_W-1:0] cnt;
      logic            lvl;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt <= '0;
            lvl <= 1'b0;
         end else if (synced[ch] == lvl) begin
            cnt <= '0;
         end else if (cnt == FC_W'(FILT_LEN - 1)) begin
            cnt <= '0;
            lvl <= synced[ch];
         end else begin
            cnt <= cnt + FC_W'(1);
         end
      end

      assign ab[ch] = lvl;
   end
`else
   assign ab = synced;
`endif

   // Map AB onto a 0..3 ring (00,10,11,01) so the step is a modular difference
   always_comb begin
      idx_cur  = {ab[0], ab[1] ^ ab[0]};
      idx_prev = {prev_ab[0], prev_ab[1] ^ prev_ab[0]};
      idx_diff = idx_cur - idx_prev;
      fwd      = (idx_diff == 2'd1);
      rev      = (idx_diff == 2'd3);
      illegal  = (idx_diff == 2'd2);
   end

   always_comb begin
      delta = '0;
      if (fwd)
         delta = '1;
      if (fwd)
         delta = (ACC_W+1)'(1);
      else if (rev)
         delta = '1;
      acc_sum = $signed({acc[ACC_W-1], acc}) + delta;
      if (acc_sum[ACC_W] != acc_sum[ACC_W-1])
         acc_next = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
      else
         acc_next = acc_sum[ACC_W-1:0];
      acc_u = acc_next;
      mag   = acc_u[ACC_W-1] ? (~acc_u + ACC_W'(1)) : acc_u;
      if (|mag[ACC_W-1:VEL_W])
         vel_sat = '1;
      else
         vel_sat = mag[VEL_W-1:0];
      win_end = (win_cnt == WIN_W'(WINDOW - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_ab   <= 2'b00;
         position  <= '0;
         velocity  <= '0;
         direction <= 1'b0;
         vel_valid <= 1'b0;
         err       <= 1'b0;
         acc       <= '0;
         win_cnt   <= '0;
      end else begin
         prev_ab   <= ab;
         vel_valid <= 1'b0;
         if (clr) begin
            position <= '0;
            velocity <= '0;
            err      <= 1'b0;
            acc      <= '0;
            win_cnt  <= '0;
         end else if (en) begin
            if (fwd)
               position <= position + POS_W'(1);
            else if (rev)
               position <= position - POS_W'(1);
            if (illegal)
               err <= 1'b1;
            if (win_end) begin
               win_cnt   <= '0;
               velocity  <= vel_sat;
               vel_valid <= 1'b1;
               acc       <= '0;
               if (acc_next != '0)
                  direction <= acc_next[ACC_W-1];
            end else begin
               win_cnt <= win_cnt + WIN_W'(1);
               acc     <= acc_next;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_quadrature_decoder.sv
//==============================================================================
// Module   : tb_quadrature_decoder
// Brief    : Directed self-checking bench for quadrature_decoder.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_quadrature_decoder;

   localparam int POS_W = 16;
   localparam int VEL_W = 8;
`ifdef QDEC_FILTER_EN
   localparam int LAT    = 7;
   localparam int GAP    = 5;
   localparam int FAST   = 5;
   localparam int WINDOW = 2000;
`else
   localparam int LAT    = 3;
   localparam int GAP    = 2;
   localparam int FAST   = 1;
   localparam int WINDOW = 400;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic             clr;
   logic             enc_a;
   logic             enc_b;
   logic [POS_W-1:0] position;
   logic [VEL_W-1:0] velocity;
   logic             direction;
   logic             vel_valid;
   logic             err;

   int n_checks = 0;
   int n_fail   = 0;
   int vv_count = 0;
   int phase    = 0;

   quadrature_decoder #(
      .POS_W(POS_W), .VEL_W(VEL_W), .WINDOW(WINDOW), .FILT_LEN(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
      .enc_a(enc_a), .enc_b(enc_b),
      .position(position), .velocity(velocity), .direction(direction),
      .vel_valid(vel_valid), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (vel_valid) vv_count++;
      end
   endtask

   // Ring order 00,10,11,01 is the forward direction
   task automatic set_phase(input int p);
      phase = p & 3;
      enc_a = (phase == 1) || (phase == 2);
      enc_b = (phase == 2) || (phase == 3);
   endtask

   task automatic step(input bit reverse, input int gap);
      set_phase(reverse ? phase + 3 : phase + 1);
      tick(gap);
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
   endtask

   task automatic wait_vv(input string tag);
      int n = 0;
      while (!vel_valid && n < WINDOW + 50) begin
         tick(1);
         n++;
      end
      check_eq(tag, {31'd0, vel_valid}, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int vv0;
      rst_n = 1'b0;
      en    = 1'b0;
      clr   = 1'b0;
      set_phase(0);
      tick(3);
      rst_n = 1'b1;
      check_eq("rst_position", 32'(position), 32'h0);
      check_eq("rst_velocity", 32'(velocity), 32'h0);
      check_eq("rst_direction", {31'd0, direction}, 32'h0);
      check_eq("rst_vel_valid", {31'd0, vel_valid}, 32'h0);
      check_eq("rst_err", {31'd0, err}, 32'h0);

      en = 1'b1;
      step(1'b0, LAT - 1);
      check_eq("latency_early", 32'(position), 32'h0);
      tick(1);
      check_eq("latency", 32'(position), 32'h1);

      do_clr();
      tick(LAT);
      repeat (8) step(1'b0, GAP);
      tick(LAT);
      check_eq("rot_fwd8", 32'(position), 32'd8);
      check_eq("rot_err", {31'd0, err}, 32'h0);
      repeat (3) step(1'b1, GAP);
      tick(LAT);
      check_eq("rot_rev3", 32'(position), 32'd5);

      do_clr();
      step(1'b1, GAP);
      tick(LAT);
      check_eq("wrap_neg", 32'(position), 32'hFFFF);

      step(1'b1, GAP);
      tick(LAT);
      do_clr();
      set_phase(2);
      tick(LAT + 4);
      check_eq("illegal_err", {31'd0, err}, 32'h1);
      check_eq("illegal_pos", 32'(position), 32'h0);
      do_clr();
      check_eq("clr_err", {31'd0, err}, 32'h0);
      check_eq("clr_pos", 32'(position), 32'h0);
      check_eq("clr_vel", 32'(velocity), 32'h0);

      en  = 1'b0;
      vv0 = vv_count;
      repeat (5) step(1'b0, GAP);
      tick(LAT);
      check_eq("dis_pos", 32'(position), 32'h0);
      check_eq("dis_vv", 32'(vv_count), 32'(vv0));
      en = 1'b1;
      tick(LAT);
      check_eq("reen_pos", 32'(position), 32'h0);
      check_eq("reen_err", {31'd0, err}, 32'h0);

      step(1'b0, LAT - 1);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      tick(LAT);
      check_eq("clr_edge_pos", 32'(position), 32'h0);

      do_clr();
      repeat (20) step(1'b0, GAP);
      wait_vv("vv_win1");
      check_eq("vel_20", 32'(velocity), 32'd20);
      check_eq("dir_fwd", {31'd0, direction}, 32'h0);
      repeat (7) step(1'b1, GAP);
      wait_vv("vv_win2");
      check_eq("vel_7", 32'(velocity), 32'd7);
      check_eq("dir_rev", {31'd0, direction}, 32'h1);
      repeat (300) step(1'b0, FAST);
      wait_vv("vv_win3");
      check_eq("vel_sat", 32'(velocity), 32'd255);
      check_eq("dir_fwd2", {31'd0, direction}, 32'h0);
      tick(1);
      check_eq("vv_pulse", {31'd0, vel_valid}, 32'h0);

`ifdef QDEC_FILTER_EN
      do_clr();
      tick(LAT);
      enc_a = ~enc_a;
      tick(2);
      enc_a = ~enc_a;
      tick(12);
      check_eq("filt_glitch", 32'(position), 32'h0);
      step(1'b0, 6);
      check_eq("filt_early", 32'(position), 32'h0);
      tick(1);
      check_eq("filt_edge", 32'(position), 32'h1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
